// File: rtl/axi_lite_reg_slice_if.sv
// AXI4-Lite bus bundle: all five channels of one link.
// The master modport drives requests (AW, W, AR) and accepts responses (B, R);
// the slave modport is the mirror image.
interface axi_lite_reg_slice_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    // write address channel
    logic [ADDR_WIDTH-1:0]   awaddr;
    logic [2:0]              awprot;
    logic                    awvalid;
    logic                    awready;

    // write data channel
    logic [DATA_WIDTH-1:0]   wdata;
    logic [DATA_WIDTH/8-1:0] wstrb;
    logic                    wvalid;
    logic                    wready;

    // write response channel
    logic [1:0]              bresp;
    logic                    bvalid;
    logic                    bready;

    // read address channel
    logic [ADDR_WIDTH-1:0]   araddr;
    logic [2:0]              arprot;
    logic                    arvalid;
    logic                    arready;

    // read data channel
    logic [DATA_WIDTH-1:0]   rdata;
    logic [1:0]              rresp;
    logic                    rvalid;
    logic                    rready;

    modport master (
        output awaddr, awprot, awvalid,
        input  awready,
        output wdata, wstrb, wvalid,
        input  wready,
        input  bresp, bvalid,
        output bready,
        output araddr, arprot, arvalid,
        input  arready,
        input  rdata, rresp, rvalid,
        output rready
    );

    modport slave (
        input  awaddr, awprot, awvalid,
        output awready,
        input  wdata, wstrb, wvalid,
        output wready,
        output bresp, bvalid,
        input  bready,
        input  araddr, arprot, arvalid,
        output arready,
        output rdata, rresp, rvalid,
        input  rready
    );
endinterface

// File: rtl/axi_lite_reg_slice.sv
// Five-channel AXI4-Lite register slice.
// Every channel is an independent two-entry skid buffer (main + skid register),
// so no valid, ready or payload path is combinational between the two ports,
// while a channel still moves one beat per cycle when downstream keeps ready high.
// Request channels (AW, W, AR) run s -> m, response channels (B, R) run m -> s.
//
// Per-channel state, encoded as {main_valid, skid_valid}:
//   state | meaning
//   EMPTY | nothing buffered, in_ready=1
//   ONE   | main holds the beat presented downstream, in_ready=1
//   FULL  | main presented, skid holds the next beat, in_ready=0
//   2'b01 | skid without main: unreachable, flagged by an assertion
module axi_lite_reg_slice #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                   aclk,
    input  logic                   areset,
    axi_lite_reg_slice_if.slave    s,
    axi_lite_reg_slice_if.master   m
);

    typedef enum logic [1:0] {
        EMPTY = 2'b00,
        ONE   = 2'b10,
        FULL  = 2'b11
    } state_t;

    localparam int NUM_CH = 5;
    localparam int CH_AW  = 0;
    localparam int CH_W   = 1;
    localparam int CH_B   = 2;
    localparam int CH_AR  = 3;
    localparam int CH_R   = 4;

    // packed payload widths per channel
    localparam int AX_BITS = ADDR_WIDTH + 3;
    localparam int W_BITS  = DATA_WIDTH + DATA_WIDTH / 8;
    localparam int B_BITS  = 2;
    localparam int R_BITS  = DATA_WIDTH + 2;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_chan

        localparam int PW = (g == CH_AW || g == CH_AR) ? AX_BITS :
                            (g == CH_W)                ? W_BITS  :
                            (g == CH_B)                ? B_BITS  : R_BITS;

        // generic view: "in" is the upstream side of the channel, "out" downstream
        logic          in_valid;
        logic [PW-1:0] in_data;
        logic          out_ready;
        logic          out_valid;

        state_t        state_q,    state_d;
        logic [PW-1:0] main_q,     main_d;
        logic [PW-1:0] skid_q,     skid_d;
        logic          in_ready_q, in_ready_d;

        logic          in_fire;
        logic          out_fire;

        assign out_valid = (state_q != EMPTY);
        assign in_fire   = in_valid && in_ready_q;
        assign out_fire  = out_valid && out_ready;

        // next-state and payload steering for the skid buffer
        always_comb begin
            state_d    = state_q;
            main_d     = main_q;
            skid_d     = skid_q;
            in_ready_d = in_ready_q;

            case (state_q)
                EMPTY: begin
                    if (in_fire) begin
                        main_d  = in_data;
                        state_d = ONE;
                    end
                end
                ONE: begin
                    if (in_fire && out_fire) begin
                        // replace the departing beat in place: full throughput
                        main_d = in_data;
                    end else if (out_fire) begin
                        state_d = EMPTY;
                    end else if (in_fire) begin
                        // downstream stalled: park the new beat behind main
                        skid_d  = in_data;
                        state_d = FULL;
                    end
                end
                FULL: begin
                    // in_ready is low here, so only the drain can happen
                    if (out_fire) begin
                        main_d  = skid_q;
                        skid_d  = '0;
                        state_d = ONE;
                    end
                end
                default: begin
                    state_d = EMPTY;
                end
            endcase

            // upstream ready is registered: it depends only on our own next state
            in_ready_d = (state_d != FULL);
        end

        // state, payload and ready registers with synchronous reset
        always_ff @(posedge aclk) begin
            if (areset) begin
                state_q    <= EMPTY;
                main_q     <= '0;
                skid_q     <= '0;
                in_ready_q <= 1'b0;
            end else begin
                state_q    <= state_d;
                main_q     <= main_d;
                skid_q     <= skid_d;
                in_ready_q <= in_ready_d;
            end
        end

        a_legal_state : assert property (@(posedge aclk) disable iff (areset)
            state_q inside {EMPTY, ONE, FULL})
            else $error("skid entry valid without main entry");

        // bind the generic channel onto the concrete AXI signals
        if (g == CH_AW) begin : g_map
            assign in_valid              = s.awvalid;
            assign in_data               = {s.awaddr, s.awprot};
            assign s.awready             = in_ready_q;
            assign m.awvalid             = out_valid;
            assign {m.awaddr, m.awprot}  = main_q;
            assign out_ready             = m.awready;
        end else if (g == CH_W) begin : g_map
            assign in_valid              = s.wvalid;
            assign in_data               = {s.wdata, s.wstrb};
            assign s.wready              = in_ready_q;
            assign m.wvalid              = out_valid;
            assign {m.wdata, m.wstrb}    = main_q;
            assign out_ready             = m.wready;
        end else if (g == CH_B) begin : g_map
            assign in_valid              = m.bvalid;
            assign in_data               = m.bresp;
            assign m.bready              = in_ready_q;
            assign s.bvalid              = out_valid;
            assign s.bresp               = main_q;
            assign out_ready             = s.bready;
        end else if (g == CH_AR) begin : g_map
            assign in_valid              = s.arvalid;
            assign in_data               = {s.araddr, s.arprot};
            assign s.arready             = in_ready_q;
            assign m.arvalid             = out_valid;
            assign {m.araddr, m.arprot}  = main_q;
            assign out_ready             = m.arready;
        end else begin : g_map
            assign in_valid              = m.rvalid;
            assign in_data               = {m.rdata, m.rresp};
            assign m.rready              = in_ready_q;
            assign s.rvalid              = out_valid;
            assign {s.rdata, s.rresp}    = main_q;
            assign out_ready             = s.rready;
        end
    end

endmodule

// File: tb/tb_axi_lite_reg_slice.sv
// Directed and random-backpressure bench for the AXI4-Lite register slice.
// Inputs change and outputs are sampled on the falling edge of aclk.
module tb_axi_lite_reg_slice;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int NBEATS = 1000;

    logic aclk;
    logic areset;

    axi_lite_reg_slice_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) s_if ();
    axi_lite_reg_slice_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) m_if ();

    axi_lite_reg_slice #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .aclk   (aclk),
        .areset (areset),
        .s      (s_if),
        .m      (m_if)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    int total = 0;
    int bad   = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    // expected payload for beat n of channel ch, packed as the DUT packs it
    function automatic logic [63:0] beat(input int ch, input int n);
        logic [31:0] v;
        logic [63:0] x;
        v = 32'(n) * 32'h9E37_79B1 + 32'(ch) * 32'h0001_1111;
        x = {v ^ 32'hC3A5_0F1E, v};
        case (ch)
            0, 3:    return x & 64'h0000_0007_FFFF_FFFF;
            1:       return x & 64'h0000_000F_FFFF_FFFF;
            2:       return x & 64'h0000_0000_0000_0003;
            default: return x & 64'h0000_0003_FFFF_FFFF;
        endcase
    endfunction

    task automatic set_in(input int ch, input logic vld, input logic [63:0] x);
        case (ch)
            0: begin s_if.awvalid = vld; {s_if.awaddr, s_if.awprot} = x[34:0]; end
            1: begin s_if.wvalid  = vld; {s_if.wdata, s_if.wstrb}   = x[35:0]; end
            2: begin m_if.bvalid  = vld; m_if.bresp                 = x[1:0];  end
            3: begin s_if.arvalid = vld; {s_if.araddr, s_if.arprot} = x[34:0]; end
            default: begin m_if.rvalid = vld; {m_if.rdata, m_if.rresp} = x[33:0]; end
        endcase
    endtask

    task automatic set_out_ready(input int ch, input logic rdy);
        case (ch)
            0: m_if.awready = rdy;
            1: m_if.wready  = rdy;
            2: s_if.bready  = rdy;
            3: m_if.arready = rdy;
            default: s_if.rready = rdy;
        endcase
    endtask

    function automatic logic get_in_ready(input int ch);
        case (ch)
            0: return s_if.awready;
            1: return s_if.wready;
            2: return m_if.bready;
            3: return s_if.arready;
            default: return m_if.rready;
        endcase
    endfunction

    function automatic logic get_out_valid(input int ch);
        case (ch)
            0: return m_if.awvalid;
            1: return m_if.wvalid;
            2: return s_if.bvalid;
            3: return m_if.arvalid;
            default: return s_if.rvalid;
        endcase
    endfunction

    function automatic logic [63:0] get_out_data(input int ch);
        case (ch)
            0: return 64'({m_if.awaddr, m_if.awprot});
            1: return 64'({m_if.wdata, m_if.wstrb});
            2: return 64'(s_if.bresp);
            3: return 64'({m_if.araddr, m_if.arprot});
            default: return 64'({s_if.rdata, s_if.rresp});
        endcase
    endfunction

    function automatic logic [4:0] all_out_valid();
        return {m_if.awvalid, m_if.wvalid, s_if.bvalid, m_if.arvalid, s_if.rvalid};
    endfunction

    function automatic logic [4:0] all_in_ready();
        return {s_if.awready, s_if.wready, m_if.bready, s_if.arready, m_if.rready};
    endfunction

    initial begin
        #400000;
        $display("FAIL watchdog expired t=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int b_cnt;
        int r_cnt;
        int ar_seen;
        int cyc;
        int in_n  [5];
        int out_n [5];
        logic in_v  [5];
        logic stall [5];
        logic [63:0] stall_data [5];
        logic rdy;
        logic [63:0] od;

        areset = 1'b1;
        for (int ch = 0; ch < 5; ch++) begin
            set_in(ch, 1'b0, 64'h0);
            set_out_ready(ch, 1'b0);
        end

        // ---------------- reset ----------------
        s_if.awvalid = 1'b1;
        s_if.awaddr  = 32'h100;
        for (int i = 0; i < 3; i++) begin
            @(negedge aclk);
            check_eq("rst_valids", 64'(all_out_valid()), 64'h0);
            check_eq("rst_readys", 64'(all_in_ready()), 64'h0);
        end
        areset = 1'b0;
        @(negedge aclk);
        check_eq("rel_awready", 64'(s_if.awready), 64'h1);
        check_eq("rel_readys", 64'(all_in_ready()), 64'h1F);
        check_eq("rel_awvalid", 64'(m_if.awvalid), 64'h0);
        s_if.awvalid = 1'b0;

        // ---------------- streaming AW ----------------
        m_if.awready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            check_eq("aw_stream_rdy", 64'(s_if.awready), 64'h1);
            s_if.awaddr  = 32'(i * 4);
            s_if.awprot  = 3'(i);
            s_if.awvalid = 1'b1;
            @(negedge aclk);
            check_eq("aw_stream_vld", 64'(m_if.awvalid), 64'h1);
            check_eq("aw_stream_addr", 64'(m_if.awaddr), 64'(i * 4));
            check_eq("aw_stream_prot", 64'(m_if.awprot), 64'(i % 8));
        end
        s_if.awvalid = 1'b0;
        @(negedge aclk);
        check_eq("aw_stream_end", 64'(m_if.awvalid), 64'h0);
        check_eq("aw_stream_rdy_end", 64'(s_if.awready), 64'h1);

        // ---------------- stall / skid on W ----------------
        m_if.wready = 1'b0;
        s_if.wdata  = 32'hA5A5_A5A5;
        s_if.wstrb  = 4'hF;
        s_if.wvalid = 1'b1;
        @(negedge aclk);
        check_eq("w_first_vld", 64'(m_if.wvalid), 64'h1);
        check_eq("w_first_data", 64'(m_if.wdata), 64'hA5A5_A5A5);
        check_eq("w_first_rdy", 64'(s_if.wready), 64'h1);
        s_if.wdata = 32'h5A5A_5A5A;
        @(negedge aclk);
        check_eq("w_full_rdy", 64'(s_if.wready), 64'h0);
        check_eq("w_full_data", 64'(m_if.wdata), 64'hA5A5_A5A5);
        s_if.wvalid = 1'b0;
        s_if.wdata  = 32'h0;
        @(negedge aclk);
        check_eq("w_hold_rdy", 64'(s_if.wready), 64'h0);
        check_eq("w_hold_data", 64'(m_if.wdata), 64'hA5A5_A5A5);
        check_eq("w_hold_strb", 64'(m_if.wstrb), 64'hF);
        m_if.wready = 1'b1;
        @(negedge aclk);
        check_eq("w_drain1_vld", 64'(m_if.wvalid), 64'h1);
        check_eq("w_drain1_data", 64'(m_if.wdata), 64'h5A5A_5A5A);
        check_eq("w_drain1_rdy", 64'(s_if.wready), 64'h1);
        @(negedge aclk);
        check_eq("w_drain2_vld", 64'(m_if.wvalid), 64'h0);
        m_if.wready = 1'b0;

        // ---------------- reverse B / R ----------------
        check_eq("br_in_rdy", 64'({m_if.bready, m_if.rready}), 64'h3);
        m_if.bresp  = 2'b10;
        m_if.bvalid = 1'b1;
        m_if.rdata  = 32'hDEAD_BEEF;
        m_if.rresp  = 2'b00;
        m_if.rvalid = 1'b1;
        @(negedge aclk);
        m_if.bvalid = 1'b0;
        m_if.bresp  = 2'b00;
        m_if.rvalid = 1'b0;
        m_if.rdata  = 32'h0;
        m_if.rresp  = 2'b11;
        check_eq("br_latency", 64'({s_if.bvalid, s_if.rvalid}), 64'h3);
        b_cnt = 0;
        r_cnt = 0;
        for (int c = 0; c < 6; c++) begin
            s_if.bready = (c % 2) == 1;
            s_if.rready = (c % 2) == 0;
            if (s_if.bvalid) begin
                check_eq("b_resp", 64'(s_if.bresp), 64'h2);
                if (s_if.bready) b_cnt++;
            end
            if (s_if.rvalid) begin
                check_eq("r_data", 64'({s_if.rdata, s_if.rresp}), {30'h0, 32'hDEAD_BEEF, 2'b00});
                if (s_if.rready) r_cnt++;
            end
            @(negedge aclk);
        end
        check_eq("b_count", 64'(b_cnt), 64'h1);
        check_eq("r_count", 64'(r_cnt), 64'h1);
        check_eq("br_idle", 64'({s_if.bvalid, s_if.rvalid}), 64'h0);

        // ---------------- random back-pressure, all channels ----------------
        for (int ch = 0; ch < 5; ch++) begin
            in_n[ch]       = 0;
            out_n[ch]      = 0;
            in_v[ch]       = 1'b0;
            stall[ch]      = 1'b0;
            stall_data[ch] = 64'h0;
        end
        cyc = 0;
        while ((out_n[0] < NBEATS || out_n[1] < NBEATS || out_n[2] < NBEATS ||
                out_n[3] < NBEATS || out_n[4] < NBEATS) && cyc < 15000) begin
            for (int ch = 0; ch < 5; ch++) begin
                od = get_out_data(ch);
                if (stall[ch]) begin
                    check_eq("rnd_hold_vld", 64'(get_out_valid(ch)), 64'h1);
                    check_eq("rnd_hold_data", od, stall_data[ch]);
                end
                if (!in_v[ch] && in_n[ch] < NBEATS)
                    in_v[ch] = 1'($urandom_range(0, 1));
                set_in(ch, in_v[ch], beat(ch, in_n[ch]));
                rdy = 1'($urandom_range(0, 1));
                set_out_ready(ch, rdy);
                if (in_v[ch] && get_in_ready(ch)) begin
                    in_n[ch]++;
                    in_v[ch] = 1'b0;
                end
                if (get_out_valid(ch)) begin
                    if (rdy) begin
                        check_eq("rnd_order", od, beat(ch, out_n[ch]));
                        out_n[ch]++;
                        stall[ch] = 1'b0;
                    end else begin
                        stall[ch]      = 1'b1;
                        stall_data[ch] = od;
                    end
                end else begin
                    stall[ch] = 1'b0;
                end
            end
            @(negedge aclk);
            cyc++;
        end
        for (int ch = 0; ch < 5; ch++) begin
            set_in(ch, 1'b0, 64'h0);
            set_out_ready(ch, 1'b1);
            check_eq("rnd_count", 64'(out_n[ch]), 64'(NBEATS));
        end
        @(negedge aclk);
        check_eq("rnd_no_extra", 64'(all_out_valid()), 64'h0);

        // ---------------- mid-operation reset on AR ----------------
        m_if.arready = 1'b0;
        s_if.araddr  = 32'h40;
        s_if.arprot  = 3'h0;
        s_if.arvalid = 1'b1;
        @(negedge aclk);
        check_eq("ar_fill1_rdy", 64'(s_if.arready), 64'h1);
        s_if.araddr = 32'h44;
        @(negedge aclk);
        check_eq("ar_full_rdy", 64'(s_if.arready), 64'h0);
        check_eq("ar_full_addr", 64'(m_if.araddr), 64'h40);
        s_if.arvalid = 1'b0;
        areset = 1'b1;
        @(negedge aclk);
        check_eq("ar_rst_vld", 64'(m_if.arvalid), 64'h0);
        check_eq("ar_rst_rdy", 64'(s_if.arready), 64'h0);
        areset = 1'b0;
        m_if.arready = 1'b1;
        ar_seen = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge aclk);
            if (m_if.arvalid) ar_seen++;
        end
        check_eq("ar_no_stale", 64'(ar_seen), 64'h0);
        check_eq("ar_rdy_back", 64'(s_if.arready), 64'h1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/axi_lite_reg_slice.md
Name: axi_lite_reg_slice

Overview:
- Full five-channel AXI4-Lite register slice between one axi_lite_master port and its axi_lite_interconnect port.
- Breaks every combinational valid/ready/payload path in both directions while sustaining one transfer per cycle per channel.
- Forward channels (AW, W, AR) flow slave side (s_*) to master side (m_*); reverse channels (B, R) flow m_* to s_*.
- Each channel is an independent 2-entry skid buffer: main register plus skid register.

Parameters:
- ADDR_WIDTH, 32, width of awaddr/araddr.
- DATA_WIDTH, 32, width of wdata/rdata; wstrb width is DATA_WIDTH/8; must be 32 or 64.

Ports:
- aclk  input  1  clock, all logic on rising edge.
- areset  input  1  synchronous active-high reset.
- s_awaddr/s_awprot/s_awvalid  input  ADDR_WIDTH/3/1; s_awready  output  1  upstream AW.
- s_wdata/s_wstrb/s_wvalid  input  DATA_WIDTH/DATA_WIDTH/8/1; s_wready  output  1  upstream W.
- s_bresp/s_bvalid  output  2/1; s_bready  input  1  upstream B.
- s_araddr/s_arprot/s_arvalid  input  ADDR_WIDTH/3/1; s_arready  output  1  upstream AR.
- s_rdata/s_rresp/s_rvalid  output  DATA_WIDTH/2/1; s_rready  input  1  upstream R.
- m_awaddr/m_awprot/m_awvalid  output; m_awready  input  downstream AW (same widths).
- m_wdata/m_wstrb/m_wvalid  output; m_wready  input  downstream W.
- m_bresp/m_bvalid  input; m_bready  output  downstream B.
- m_araddr/m_arprot/m_arvalid  output; m_arready  input  downstream AR.
- m_rdata/m_rresp/m_rvalid  input; m_rready  output  downstream R.

Behaviour:
- Clock is aclk. Reset is synchronous, active-high, port areset. These are fixed.
- Generic channel: input side in_valid/in_ready/in_data, output side out_valid/out_ready/out_data. Forward channels map in=s, out=m; reverse channels map in=m, out=s.
- Reset (areset=1 at an edge):
  - all out_valid=0, all skid flags=0, all in_ready=0.
  - Payload registers are don't-care but are cleared to 0.
  - First edge with areset=0 sets in_ready=1.
- in_ready is a flop, never combinational from out_ready. It equals !skid_full after every non-reset edge.
- State per channel, as (main_valid, skid_valid):
  - EMPTY (0,0):
    - in handshake -> main<=data -> ONE.
  - ONE (1,0):
    - out handshake and no in handshake -> EMPTY.
    - in handshake and out handshake -> main<=new data, stay ONE (full throughput).
    - in handshake without out handshake -> skid<=data -> FULL, in_ready<=0.
    - Neither -> hold.
  - FULL (1,1):
    - in_ready=0. On out handshake -> main<=skid, skid cleared -> ONE, in_ready<=1.
- Latency is exactly 1 cycle from in handshake to out_valid when the channel is empty. A stalled beat behind a full main waits in skid.
- out_valid/out_data: once out_valid=1, payload is held stable until the out handshake (AXI rule). out_valid never drops without a handshake.
- Ordering: strict FIFO per channel. No beat is dropped or duplicated.
- Channels are fully independent. No AW/W coupling, no outstanding-transaction tracking, no payload modification (resp, prot, strb pass bit-exact).
- Throughput: with out_ready held 1, a back-to-back input stream passes at 1 beat/cycle with in_ready constantly 1.
- Reset mid-operation: all buffered beats are discarded and valids drop the cycle after the reset edge. The surrounding master/slave reset together.
- Only these entries are legal: EMPTY, ONE, FULL. skid_valid=1 with main_valid=0 is unreachable; assert on it in simulation.

Test Plan:
- Reset:
  - Hold areset=1 for 3 cycles with s_awvalid=1.
  - Required: all *valid outputs are 0 and all *ready outputs are 0 during reset; s_awready=1 on the first cycle after release.
- Streaming AW:
  - Drive 8 back-to-back addresses 0x00..0x1C (step 4) with m_awready=1.
  - Required: m_awaddr sequence 0x00..0x1C, each exactly 1 cycle after its s handshake; s_awready never 0.
- Stall/skid W:
  - m_wready=0; push wdata 0xA5A5A5A5 then 0x5A5A5A5A, wstrb 0xF.
  - Required: s_wready=0 after the 2nd beat; m_wdata holds 0xA5A5A5A5.
  - Raise m_wready: required order 0xA5A5A5A5 then 0x5A5A5A5A; s_wready=1 one cycle after the first drain.
- Reverse B/R:
  - m_bresp=2'b10 and m_rdata=0xDEADBEEF/m_rresp=0, with s_bready/s_rready toggled each cycle.
  - Required: s_bresp=2'b10 and s_rdata=0xDEADBEEF delivered exactly once each; payload stable while valid&&!ready.
- Random back-pressure:
  - 1000 random beats per channel with random valid/ready at 50%.
  - Required: scoreboard shows in-order, lossless output and no valid drop without handshake.
- Mid-operation reset:
  - Fill AR to FULL (araddr 0x40, 0x44), then assert areset for 1 cycle.
  - Required: m_arvalid=0 next cycle; neither 0x40 nor 0x44 appears after reset.
